// File: rtl/submodule_cmd_pkg.sv
// submodule_cmd_pkg: frame layout, command codes and state encodings shared by the sub-module command decoder
// Contents:
//   frame bit positions  FRM_START, CPL_HI/CPL_LO (complement field), SYN_BIT, CON_HI/CON_LO, FRM_STOP
//   con code constants   CON_*
//   mod_state_t          LOCKED / RUN / BYPASS / FAULT as seen on the mod_state port
//   leg_tgt_t            per-leg gate target (off, upper on, lower on)
package submodule_cmd_pkg;
    localparam int FRM_START = 11;
    localparam int CPL_HI    = 10;
    localparam int CPL_LO    = 6;
    localparam int SYN_BIT   = 5;
    localparam int CON_HI    = 4;
    localparam int CON_LO    = 1;
    localparam int FRM_STOP  = 0;

    localparam logic [3:0] CON_LOCK       = 4'b0001;
    localparam logic [3:0] CON_LOCK_RST   = 4'b0010;
    localparam logic [3:0] CON_BYPASS     = 4'b0110;
    localparam logic [3:0] CON_BYPASS_RST = 4'b1001;
    localparam logic [3:0] CON_ALL_ON     = 4'b1101;
    localparam logic [3:0] CON_LEFT       = 4'b1010;
    localparam logic [3:0] CON_RIGHT      = 4'b1100;
    localparam logic [3:0] CON_ALL_OFF    = 4'b1110;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        RUN    = 2'd1,
        BYPASS = 2'd2,
        FAULT  = 2'd3
    } mod_state_t;

    typedef enum logic [1:0] {
        LEG_OFF   = 2'd0,
        LEG_UPPER = 2'd1,
        LEG_LOWER = 2'd2
    } leg_tgt_t;

    function automatic logic con_is_run(input logic [3:0] c);
        return c inside {CON_ALL_ON, CON_LEFT, CON_RIGHT, CON_ALL_OFF};
    endfunction

    function automatic logic con_legal(input logic [3:0] c);
        return con_is_run(c) || c inside {CON_LOCK, CON_LOCK_RST, CON_BYPASS, CON_BYPASS_RST};
    endfunction
endpackage

// File: rtl/leg_deadtime.sv
// leg_deadtime: drives the upper/lower gate pair of one bridge leg with dead-time insertion
// Ports:
//   clk_20M  in   system clock
//   reset    in   asynchronous active-high reset, gates drop immediately
//   target   in   leg_tgt_t requested state of the leg
//   upper    out  upper switch gate, 1 = on
//   lower    out  lower switch gate, 1 = on
module leg_deadtime
    import submodule_cmd_pkg::*;
#(
    parameter int DEADTIME = 40
) (
    input  logic       clk_20M,
    input  logic       reset,
    input  logic [1:0] target,
    output logic       upper,
    output logic       lower
);
    localparam int CW = $clog2(DEADTIME + 1);

    // cnt is the number of consecutive cycles, including the current one, with both gates off (saturating)
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ok, up_nxt, lo_nxt;

    assign ok      = cnt == CW'(DEADTIME);
    assign up_nxt  = target == LEG_UPPER && (upper || (!lower && ok));
    assign lo_nxt  = target == LEG_LOWER && (lower || (!upper && ok));
    assign cnt_nxt = (up_nxt || lo_nxt) ? '0 : ok ? cnt : cnt + 1'b1;

    // preset to DEADTIME so the first turn-on after reset is not delayed
    always_ff @(posedge clk_20M or posedge reset) begin
        if (reset) begin
            upper <= 1'b0;
            lower <= 1'b0;
            cnt   <= CW'(DEADTIME);
        end else begin
            upper <= up_nxt;
            lower <= lo_nxt;
            cnt   <= cnt_nxt;
        end
    end
endmodule

// File: rtl/submodule_cmd_decoder.sv
// submodule_cmd_decoder: checks and decodes received command frames, drives the full-bridge gates and bypass
// Ports:
//   clk_20M    in   system clock, 20 MHz
//   reset      in   asynchronous active-high reset
//   rx_word    in   12-bit received frame, valid while rx_valid=1
//   rx_valid   in   one-cycle frame strobe
//   gate       out  [0]=S1 left upper, [1]=S2 left lower, [2]=S3 right upper, [3]=S4 right lower
//   bypass_on  out  bypass switch command, high exactly while in BYPASS
//   mod_state  out  0=LOCKED 1=RUN 2=BYPASS 3=FAULT
//   syn_pulse  out  one-cycle pulse per good frame carrying syn=1
//   frame_err  out  one-cycle pulse per bad frame
//   err_cnt    out  total bad frames, saturating at 255
module submodule_cmd_decoder
    import submodule_cmd_pkg::*;
#(
    parameter int FRAME_PERIOD = 156,
    parameter int WDOG_FRAMES  = 4,
    parameter int ERR_LIMIT    = 3,
    parameter int DEADTIME     = 40
) (
    input  logic        clk_20M,
    input  logic        reset,
    input  logic [11:0] rx_word,
    input  logic        rx_valid,
    output logic [3:0]  gate,
    output logic        bypass_on,
    output logic [1:0]  mod_state,
    output logic        syn_pulse,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);
    localparam int TIMEOUT = FRAME_PERIOD * WDOG_FRAMES;
    localparam int WW      = $clog2(TIMEOUT + 1);

    mod_state_t    st, st_nxt;
    leg_tgt_t      left_tgt, right_tgt, left_nxt, right_nxt, cmd_left, cmd_right;
    logic [WW-1:0] wdog, wdog_nxt;
    logic [7:0]    cons, cons_nxt, err_nxt;
    logic [3:0]    con;
    logic          good, bad, expired;

    assign con     = rx_word[CON_HI:CON_LO];
    assign good    = rx_valid && !rx_word[FRM_START] && !rx_word[FRM_STOP]
                     && rx_word[CPL_HI:CPL_LO] == ~rx_word[SYN_BIT:CON_LO] && con_legal(con);
    assign bad     = rx_valid && !good;
    // wdog counts clocks since the rx_valid of the last good frame, so expiry lands on the same edge as a frame sent then
    assign expired = st == RUN && wdog == WW'(TIMEOUT - 1);

    always_comb begin
        cons_nxt  = good ? '0 : (bad && cons < 8'(ERR_LIMIT)) ? cons + 8'd1 : cons;
        err_nxt   = (good && con == CON_LOCK_RST && st != BYPASS) ? '0
                  : (bad && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
        wdog_nxt  = good ? WW'(1) : (wdog == WW'(TIMEOUT)) ? wdog : wdog + 1'b1;
        cmd_left  = (con == CON_ALL_ON || con == CON_LEFT) ? LEG_UPPER : (con == CON_RIGHT) ? LEG_LOWER : LEG_OFF;
        cmd_right = (con == CON_LEFT) ? LEG_UPPER : (con == CON_ALL_ON || con == CON_RIGHT) ? LEG_LOWER : LEG_OFF;
        st_nxt    = st;
        // a good frame always takes precedence over a watchdog expiry on the same cycle
        if (good) begin
            case (st)
                LOCKED, RUN: st_nxt = con_is_run(con) ? RUN
                                    : (con == CON_LOCK || con == CON_LOCK_RST) ? LOCKED
                                    : (con == CON_BYPASS) ? BYPASS : st;
                BYPASS:      st_nxt = (con == CON_BYPASS_RST) ? LOCKED : BYPASS;
                default:     st_nxt = (con == CON_LOCK_RST) ? LOCKED : (con == CON_BYPASS) ? BYPASS : FAULT;
            endcase
        end else if ((bad && (st == LOCKED || st == RUN) && cons_nxt >= 8'(ERR_LIMIT)) || expired) begin
            st_nxt = FAULT;
        end
        left_nxt  = (st_nxt != RUN) ? LEG_OFF : (good && con_is_run(con)) ? cmd_left : left_tgt;
        right_nxt = (st_nxt != RUN) ? LEG_OFF : (good && con_is_run(con)) ? cmd_right : right_tgt;
    end

    always_ff @(posedge clk_20M or posedge reset) begin
        if (reset) begin
            st        <= LOCKED;
            left_tgt  <= LEG_OFF;
            right_tgt <= LEG_OFF;
            cons      <= '0;
            err_cnt   <= '0;
            wdog      <= '0;
            frame_err <= 1'b0;
            syn_pulse <= 1'b0;
        end else begin
            st        <= st_nxt;
            left_tgt  <= left_nxt;
            right_tgt <= right_nxt;
            cons      <= cons_nxt;
            err_cnt   <= err_nxt;
            wdog      <= wdog_nxt;
            frame_err <= bad;
            syn_pulse <= good && rx_word[SYN_BIT];
        end
    end

    assign mod_state = st;
    assign bypass_on = st == BYPASS;

    leg_deadtime #(.DEADTIME(DEADTIME)) u_left (
        .clk_20M (clk_20M),
        .reset   (reset),
        .target  (left_tgt),
        .upper   (gate[0]),
        .lower   (gate[1])
    );

    leg_deadtime #(.DEADTIME(DEADTIME)) u_right (
        .clk_20M (clk_20M),
        .reset   (reset),
        .target  (right_tgt),
        .upper   (gate[2]),
        .lower   (gate[3])
    );
endmodule

// File: tb/tb_submodule_cmd_decoder.sv
// tb_submodule_cmd_decoder: frame table plus hand-written timing sequences, scoreboard-checked decoder outputs
module tb_submodule_cmd_decoder;
    localparam logic [1:0] S_LOCKED = 2'd0, S_RUN = 2'd1, S_BYPASS = 2'd2, S_FAULT = 2'd3;

    logic        clk_20M = 1'b0, reset = 1'b0, rx_valid = 1'b0, run_mon = 1'b0, vd;
    logic [11:0] rx_word = '0;
    logic [3:0]  gate;
    logic        bypass_on, syn_pulse, frame_err;
    logic [1:0]  mod_state;
    logic [7:0]  err_cnt;
    int          n_tests = 0, n_fail = 0;

    typedef struct {
        logic [1:0] st;
        logic       ferr;
        logic       syn;
        logic [7:0] errc;
    } exp_t;

    typedef struct {
        logic [11:0] word;
        logic [1:0]  st;
        logic        ferr;
        logic        syn;
        logic [7:0]  errc;
        logic [3:0]  gate;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[17];

    submodule_cmd_decoder dut (
        .clk_20M   (clk_20M),
        .reset     (reset),
        .rx_word   (rx_word),
        .rx_valid  (rx_valid),
        .gate      (gate),
        .bypass_on (bypass_on),
        .mod_state (mod_state),
        .syn_pulse (syn_pulse),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #25 clk_20M = ~clk_20M;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [11:0] w, input logic [1:0] st, input logic ferr, input logic syn,
                        input logic [7:0] errc);
        exp_t e;
        e.st = st; e.ferr = ferr; e.syn = syn; e.errc = errc;
        sb.push_back(e);
        @(negedge clk_20M);
        rx_word  = w;
        rx_valid = 1'b1;
        @(negedge clk_20M);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_20M);
    endtask

    task automatic do_reset();
        @(negedge clk_20M);
        reset    = 1'b1;
        rx_valid = 1'b0;
        sb.delete();
        #1;
        check("rst_gate", 32'(gate), 0);
        check("rst_state", 32'(mod_state), 32'(S_LOCKED));
        check("rst_bypass", 32'(bypass_on), 0);
        check("rst_errcnt", 32'(err_cnt), 0);
        check("rst_ferr", 32'(frame_err), 0);
        @(negedge clk_20M);
        reset   = 1'b0;
        run_mon = 1'b1;
    endtask

    // vd marks the cycle after a frame strobe, when the registered decode must show that frame's result
    always @(posedge clk_20M or posedge reset) vd <= reset ? 1'b0 : rx_valid;

    always @(negedge clk_20M) begin
        exp_t e;
        if (run_mon && !reset) begin
            check("shoot_left", 32'(gate[0] & gate[1]), 0);
            check("shoot_right", 32'(gate[2] & gate[3]), 0);
            if (vd) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: output with no expected entry");
                end else begin
                    e = sb.pop_front();
                    check("sb_state", 32'(mod_state), 32'(e.st));
                    check("sb_ferr", 32'(frame_err), 32'(e.ferr));
                    check("sb_syn", 32'(syn_pulse), 32'(e.syn));
                    check("sb_errcnt", 32'(err_cnt), 32'(e.errc));
                    check("sb_bypass", 32'(bypass_on), 32'(e.st == S_BYPASS));
                end
            end else begin
                check("idle_ferr", 32'(frame_err), 0);
                check("idle_syn", 32'(syn_pulse), 0);
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int drop, rise;
        logic g3ok;
        tbl[0]  = '{12'h49A, S_RUN,    1'b0, 1'b0, 8'd0, 4'b1001};
        tbl[1]  = '{12'h4D8, S_RUN,    1'b0, 1'b0, 8'd0, 4'b1010};
        tbl[2]  = '{12'h554, S_RUN,    1'b0, 1'b0, 8'd0, 4'b0101};
        tbl[3]  = '{12'h09A, S_RUN,    1'b1, 1'b0, 8'd1, 4'b0101};
        tbl[4]  = '{12'h45C, S_RUN,    1'b0, 1'b0, 8'd1, 4'b0000};
        tbl[5]  = '{12'h782, S_LOCKED, 1'b0, 1'b0, 8'd1, 4'b0000};
        tbl[6]  = '{12'hC9A, S_LOCKED, 1'b1, 1'b0, 8'd2, 4'b0000};
        tbl[7]  = '{12'h49B, S_LOCKED, 1'b1, 1'b0, 8'd3, 4'b0000};
        tbl[8]  = '{12'h7C0, S_FAULT,  1'b1, 1'b0, 8'd4, 4'b0000};
        tbl[9]  = '{12'h49A, S_FAULT,  1'b0, 1'b0, 8'd4, 4'b0000};
        tbl[10] = '{12'h64C, S_BYPASS, 1'b0, 1'b0, 8'd4, 4'b0000};
        tbl[11] = '{12'h744, S_BYPASS, 1'b0, 1'b0, 8'd4, 4'b0000};
        tbl[12] = '{12'h592, S_LOCKED, 1'b0, 1'b0, 8'd4, 4'b0000};
        tbl[13] = '{12'h744, S_LOCKED, 1'b0, 1'b0, 8'd0, 4'b0000};
        tbl[14] = '{12'h0BA, S_RUN,    1'b0, 1'b1, 8'd0, 4'b1001};
        tbl[15] = '{12'h592, S_RUN,    1'b0, 1'b0, 8'd0, 4'b1001};
        tbl[16] = '{12'h64C, S_BYPASS, 1'b0, 1'b0, 8'd0, 4'b0000};

        do_reset();
        foreach (tbl[i]) begin
            send(tbl[i].word, tbl[i].st, tbl[i].ferr, tbl[i].syn, tbl[i].errc);
            idle(50);
            check($sformatf("vec%0d_gate", i), 32'(gate), 32'(tbl[i].gate));
        end

        // ALL_ON latency, then RIGHT: left upper drops at N+2, left lower rises at N+42
        do_reset();
        send(12'h49A, S_RUN, 1'b0, 1'b0, 8'd0);
        check("t1_gate_n1", 32'(gate), 0);
        idle(1);
        check("t1_gate_n2", 32'(gate), 32'(4'b1001));
        idle(10);
        send(12'h4D8, S_RUN, 1'b0, 1'b0, 8'd0);
        check("t2_gate_n1", 32'(gate), 32'(4'b1001));
        drop = -1; rise = -1; g3ok = 1'b1;
        for (int k = 2; k <= 45; k++) begin
            idle(1);
            if (!gate[0] && drop < 0) drop = k;
            if (gate[1] && rise < 0) rise = k;
            if (!gate[3]) g3ok = 1'b0;
        end
        check("t2_drop_cycle", 32'(drop), 2);
        check("t2_rise_cycle", 32'(rise), 42);
        check("t2_s4_held", 32'(g3ok), 1);

        // watchdog expiry 624 clocks after the last good frame
        do_reset();
        send(12'h49A, S_RUN, 1'b0, 1'b0, 8'd0);
        idle(622);
        check("wd_before", 32'(mod_state), 32'(S_RUN));
        idle(1);
        check("wd_expire", 32'(mod_state), 32'(S_FAULT));
        idle(1);
        check("wd_gate", 32'(gate), 0);

        // a good frame on the expiry cycle keeps RUN
        do_reset();
        send(12'h49A, S_RUN, 1'b0, 1'b0, 8'd0);
        idle(621);
        send(12'h49A, S_RUN, 1'b0, 1'b0, 8'd0);
        idle(5);
        check("wd_rescue", 32'(mod_state), 32'(S_RUN));
        check("wd_rescue_gate", 32'(gate), 32'(4'b1001));

        // asynchronous reset in the middle of a dead-time window
        do_reset();
        send(12'h0BA, S_RUN, 1'b0, 1'b1, 8'd0);
        idle(3);
        send(12'h4D8, S_RUN, 1'b0, 1'b0, 8'd0);
        idle(10);
        check("dt_window_gate", 32'(gate), 32'(4'b1000));
        #5 reset = 1'b1;
        #1;
        check("async_rst_gate", 32'(gate), 0);
        check("async_rst_state", 32'(mod_state), 32'(S_LOCKED));
        sb.delete();
        @(negedge clk_20M);
        reset = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
